// File: rtl/led_pos_display_pkg.sv
// Shared types and constants for the LED position display.
//   dir_t   : direction of the last valid move.
//   scan_t  : digit-scan state (DIG0 is the rightmost digit).
//   glyph_t : symbolic glyph codes fed to seg7_glyph.
//   SEG_*   : active-low segment patterns, bit order {g,f,e,d,c,b,a}.
package led_pos_display_pkg;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    DIG0,
    DIG1,
    DIG2,
    DIG3
  } scan_t;

  // DIGITn occupy codes 0..9 so a decimal digit casts straight to its glyph.
  typedef enum logic [3:0] {
    DIGIT0      = 4'd0,
    DIGIT1      = 4'd1,
    DIGIT2      = 4'd2,
    DIGIT3      = 4'd3,
    DIGIT4      = 4'd4,
    DIGIT5      = 4'd5,
    DIGIT6      = 4'd6,
    DIGIT7      = 4'd7,
    DIGIT8      = 4'd8,
    DIGIT9      = 4'd9,
    GLYPH_L     = 4'd10,
    GLYPH_R     = 4'd11,
    GLYPH_DASH  = 4'd12,
    GLYPH_BLANK = 4'd13
  } glyph_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digit (0..9) to its glyph code.
  function automatic glyph_t digit_glyph(input logic [3:0] value);
    return glyph_t'(value);
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph-code to seven-segment decoder.
//   code : glyph_t value (4 bits)
//   seg  : active-low segments {g,f,e,d,c,b,a}; unused codes show blank.
module seg7_glyph
  import led_pos_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph_t'(code))
      DIGIT0:      seg = SEG_0;
      DIGIT1:      seg = SEG_1;
      DIGIT2:      seg = SEG_2;
      DIGIT3:      seg = SEG_3;
      DIGIT4:      seg = SEG_4;
      DIGIT5:      seg = SEG_5;
      DIGIT6:      seg = SEG_6;
      DIGIT7:      seg = SEG_7;
      DIGIT8:      seg = SEG_8;
      DIGIT9:      seg = SEG_9;
      GLYPH_L:     seg = SEG_L;
      GLYPH_R:     seg = SEG_R;
      GLYPH_DASH:  seg = SEG_DASH;
      GLYPH_BLANK: seg = SEG_BLANK;
      default:     seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_position_display.sv
// Encodes the one-hot LED position bar into an index, tracks the direction
// of the last move and scans it onto the Basys3 4-digit seven-segment display.
//   clk, rst_n : system clock, asynchronous active-low reset
//   led        : one-hot position from the shifter (same clock domain)
//   seg, dp    : active-low segments {g,f,e,d,c,b,a} and decimal point (off)
//   an         : active-low digit anodes, an[0] rightmost
//   pos        : index of the set led bit (holds last valid value)
//   pos_valid  : registered led has exactly one bit set
// Optional feature: define LED_POS_DISPLAY_MOVE_CNT_EN to show a 0..99 move
// counter on d3/d2 instead of the direction letter.
module led_position_display
  import led_pos_display_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] led,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [3:0]  pos,
  output logic        pos_valid
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  logic [15:0]      led_q;
  logic [3:0]       enc_idx;
  logic             enc_valid;
  logic             dir_upd;
  dir_t             dir;
  scan_t            state, state_next;
  logic [CNT_W-1:0] dwell;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  glyph_t           sel, d0, d1, d2, d3;
  logic [3:0]       ones;

  // Exactly one bit set <=> nonzero and clearing the lowest set bit gives zero.
  always_comb begin
    enc_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (led_q[i]) enc_idx = 4'(i);
    end
    enc_valid = (led_q != '0) && ((led_q & (led_q - 16'd1)) == '0);
  end

  // pos_valid/pos still hold the previous encode, so they are the "old" side.
  assign dir_upd = pos_valid && enc_valid && (enc_idx != pos);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      pos       <= '0;
      pos_valid <= 1'b0;
      dir       <= DIR_NONE;
    end else begin
      led_q     <= led;
      pos_valid <= enc_valid;
      if (enc_valid) pos <= enc_idx;
      if (dir_upd) dir <= (enc_idx > pos) ? DIR_LEFT : DIR_RIGHT;
    end
  end

`ifdef LED_POS_DISPLAY_MOVE_CNT_EN
  logic [7:0] move_cnt;
  logic [7:0] cnt_tens, cnt_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_cnt <= '0;
    end else if (dir_upd) begin
      move_cnt <= (move_cnt == 8'd99) ? '0 : move_cnt + 8'd1;
    end
  end

  always_comb begin
    cnt_tens = move_cnt / 8'd10;
    cnt_ones = move_cnt % 8'd10;
    d3       = digit_glyph(cnt_tens[3:0]);
    d2       = digit_glyph(cnt_ones[3:0]);
  end
`else
  always_comb begin
    d2 = GLYPH_BLANK;
    case (dir)
      DIR_LEFT:  d3 = GLYPH_L;
      DIR_RIGHT: d3 = GLYPH_R;
      default:   d3 = GLYPH_BLANK;
    endcase
  end
`endif

  // pos is at most 15, so the tens digit is either blank or 1.
  always_comb begin
    ones = (pos >= 4'd10) ? pos - 4'd10 : pos;
    if (!pos_valid) begin
      d0 = GLYPH_DASH;
      d1 = GLYPH_DASH;
    end else begin
      d0 = digit_glyph(ones);
      d1 = (pos >= 4'd10) ? DIGIT1 : GLYPH_BLANK;
    end
  end

  // Scan FSM: next state plus the anode/glyph selection for the current digit.
  always_comb begin
    state_next = state;
    an_next    = '1;
    sel        = GLYPH_BLANK;
    case (state)
      DIG0: begin an_next = 4'b1110; sel = d0; end
      DIG1: begin an_next = 4'b1101; sel = d1; end
      DIG2: begin an_next = 4'b1011; sel = d2; end
      DIG3: begin an_next = 4'b0111; sel = d3; end
      default: ;
    endcase
    if (dwell == CNT_MAX) begin
      case (state)
        DIG0:    state_next = DIG1;
        DIG1:    state_next = DIG2;
        DIG2:    state_next = DIG3;
        default: state_next = DIG0;
      endcase
    end
  end

  seg7_glyph u_glyph (
    .code (sel),
    .seg  (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIG0;
      dwell <= '0;
      an    <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      state <= state_next;
      dwell <= (dwell == CNT_MAX) ? '0 : dwell + CNT_W'(1);
      an    <= an_next;
      seg   <= seg_next;
      dp    <= 1'b1;
    end
  end

endmodule
